// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
// Two requesters (A, B) share one single-port 2**ADDR_W x DATA_W memory.
// At most one access per cycle; ties go to the requester not granted most
// recently (A favoured after reset). Acks are combinational, read data
// returns one cycle after the grant.
//
// Optional feature: define MEM_ARB_INIT_CLEAR_EN to zero the whole memory
// after reset (init_busy high for 2**ADDR_W cycles, no grants meanwhile).
// Without it the arbiter runs straight out of reset with undefined contents.
//
// Ports
//   clk, rst_n                     clock, async active-low reset
//   x_req/x_we/x_addr/x_wdata/x_wmask  requester x access (x = a, b);
//                                  wmask bit0 = low half, bit1 = high half
//   x_ack                          access accepted this cycle
//   x_rvalid/x_rdata               read return, one cycle after grant
//   init_busy                      clear sequence in progress
// ---------------------------------------------------------------------------
module mem_arbiter #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    input  logic [1:0]        a_wmask,
    output logic              a_ack,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    input  logic [1:0]        b_wmask,
    output logic              b_ack,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] b_rdata,
    output logic              init_busy
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int HALF  = DATA_W / 2;

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t              r_state, w_state_nxt;
    logic                r_prio_b;     // 1: B wins the next tie
    logic [DATA_W-1:0]   r_mem [DEPTH];
    logic                r_a_rvalid, r_b_rvalid;
    logic [DATA_W-1:0]   r_a_rdata, r_b_rdata;

    logic                w_run, w_gnt_a, w_gnt_b, w_gnt;
    logic                w_we;
    logic [ADDR_W-1:0]   w_addr;
    logic [DATA_W-1:0]   w_wdata;
    logic [1:0]          w_wmask;

`ifdef MEM_ARB_INIT_CLEAR_EN
    logic [ADDR_W-1:0]   r_clr_cnt;
`endif

    // rst_n is folded in so the combinational acks drop the moment reset
    // asserts, even when the state register already reads RUN.
    always_comb begin
        w_run   = (r_state == ST_RUN) && rst_n;
        w_gnt_a = w_run && a_req && (!b_req || !r_prio_b);
        w_gnt_b = w_run && b_req && (!a_req ||  r_prio_b);
        w_gnt   = w_gnt_a || w_gnt_b;
        w_we    = w_gnt_a ? a_we    : b_we;
        w_addr  = w_gnt_a ? a_addr  : b_addr;
        w_wdata = w_gnt_a ? a_wdata : b_wdata;
        w_wmask = w_gnt_a ? a_wmask : b_wmask;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
`ifdef MEM_ARB_INIT_CLEAR_EN
            ST_INIT: if (r_clr_cnt == {ADDR_W{1'b1}}) w_state_nxt = ST_RUN;
`else
            ST_INIT: w_state_nxt = ST_RUN;
`endif
            default: w_state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
`ifdef MEM_ARB_INIT_CLEAR_EN
            r_state   <= ST_INIT;
            r_clr_cnt <= '0;
`else
            r_state   <= ST_RUN;
`endif
        end else begin
            r_state   <= w_state_nxt;
`ifdef MEM_ARB_INIT_CLEAR_EN
            if (r_state == ST_INIT) r_clr_cnt <= r_clr_cnt + ADDR_W'(1);
`endif
        end
    end

    // Memory array has no reset; the clear sequence (when built in) is the
    // only thing that gives it defined contents.
    always_ff @(posedge clk) begin
`ifdef MEM_ARB_INIT_CLEAR_EN
        if (r_state == ST_INIT) begin
            r_mem[r_clr_cnt] <= '0;
        end else
`endif
        if (w_gnt && w_we) begin
            if (w_wmask[0]) r_mem[w_addr][HALF-1:0]      <= w_wdata[HALF-1:0];
            if (w_wmask[1]) r_mem[w_addr][DATA_W-1:HALF] <= w_wdata[DATA_W-1:HALF];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prio_b   <= 1'b0;
            r_a_rvalid <= 1'b0;
            r_b_rvalid <= 1'b0;
            r_a_rdata  <= '0;
            r_b_rdata  <= '0;
        end else begin
            r_a_rvalid <= w_gnt_a && !a_we;
            r_b_rvalid <= w_gnt_b && !b_we;
            // rdata only moves on a read grant, so it holds between reads.
            if (w_gnt_a && !a_we) r_a_rdata <= r_mem[a_addr];
            if (w_gnt_b && !b_we) r_b_rdata <= r_mem[b_addr];
            if (w_gnt_a)      r_prio_b <= 1'b1;
            else if (w_gnt_b) r_prio_b <= 1'b0;
        end
    end

    assign a_ack     = w_gnt_a;
    assign b_ack     = w_gnt_b;
    assign a_rvalid  = r_a_rvalid;
    assign b_rvalid  = r_b_rvalid;
    assign a_rdata   = r_a_rdata;
    assign b_rdata   = r_b_rdata;
`ifdef MEM_ARB_INIT_CLEAR_EN
    assign init_busy = (r_state == ST_INIT);
`else
    assign init_busy = 1'b0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    localparam int AW = 4;
    localparam int DW = 8;
    localparam int DEPTH = 16;
`ifdef MEM_ARB_INIT_CLEAR_EN
    localparam int EXP_BUSY = DEPTH;
`else
    localparam int EXP_BUSY = 0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic a_req = 0, a_we = 0, b_req = 0, b_we = 0;
    logic [AW-1:0] a_addr = '0, b_addr = '0;
    logic [DW-1:0] a_wdata = '0, b_wdata = '0;
    logic [1:0] a_wmask = '0, b_wmask = '0;
    logic a_ack, a_rvalid, b_ack, b_rvalid, init_busy;
    logic [DW-1:0] a_rdata, b_rdata;

    int checks = 0;
    int errors = 0;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_wmask(a_wmask),
        .a_ack(a_ack), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_wmask(b_wmask),
        .b_ack(b_ack), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .init_busy(init_busy)
    );

    always #5 clk = ~clk;

    // Reference model: word array with a known flag per word, name of the
    // last granted side, remaining clear cycles, and the read return per side.
    logic [DW-1:0] m_mem [DEPTH];
    bit            m_known [DEPTH];
    bit            m_last_b;
    int            m_init_left;
    bit            m_a_rv, m_b_rv, m_a_rdk, m_b_rdk;
    logic [DW-1:0] m_a_rd, m_b_rd;

    task automatic model_reset();
        m_last_b = 1'b1;
        m_a_rv = 0; m_b_rv = 0; m_a_rd = '0; m_b_rd = '0; m_a_rdk = 1; m_b_rdk = 1;
        m_init_left = EXP_BUSY;
        for (int i = 0; i < DEPTH; i++) begin
`ifdef MEM_ARB_INIT_CLEAR_EN
            m_mem[i] = '0; m_known[i] = 1;
`else
            m_known[i] = 0;
`endif
        end
    endtask

    task automatic drive_a(input bit req, input bit we, input int addr, input logic [DW-1:0] d, input logic [1:0] m);
        a_req = req; a_we = we; a_addr = AW'(addr); a_wdata = d; a_wmask = m;
    endtask

    task automatic drive_b(input bit req, input bit we, input int addr, input logic [DW-1:0] d, input logic [1:0] m);
        b_req = req; b_we = we; b_addr = AW'(addr); b_wdata = d; b_wmask = m;
    endtask

    // One clock: called and returning at posedge+1. Samples acks mid-cycle and
    // read returns just after the edge; hands back observed and expected.
    task automatic cycle(output logic [4:0] oc, output logic [4:0] ec,
                         output logic [2*DW-1:0] ord, output logic [2*DW-1:0] erd,
                         output logic [2*DW-1:0] care);
        bit busy, ga, gb, we;
        int addr;
        logic [DW-1:0] d;
        logic [1:0] m;
        #3;
        busy = (m_init_left > 0);
        ga = 0; gb = 0;
        if (!busy) begin
            if (a_req && b_req) begin
                if (m_last_b) ga = 1; else gb = 1;
            end else begin
                ga = a_req; gb = b_req;
            end
        end
        oc[4:2] = {a_ack, b_ack, init_busy};
        ec[4:2] = {ga, gb, busy};
        @(posedge clk);
        if (busy) m_init_left--;
        m_a_rv = 0; m_b_rv = 0;
        if (ga || gb) begin
            we = ga ? a_we : b_we; addr = int'(ga ? a_addr : b_addr);
            d = ga ? a_wdata : b_wdata; m = ga ? a_wmask : b_wmask;
            m_last_b = gb;
            if (we) begin
                if (m[0]) m_mem[addr][DW/2-1:0] = d[DW/2-1:0];
                if (m[1]) m_mem[addr][DW-1:DW/2] = d[DW-1:DW/2];
                if (m == 2'b11) m_known[addr] = 1;
            end else if (ga) begin
                m_a_rv = 1; m_a_rd = m_mem[addr]; m_a_rdk = m_known[addr];
            end else begin
                m_b_rv = 1; m_b_rd = m_mem[addr]; m_b_rdk = m_known[addr];
            end
        end
        #1;
        oc[1:0] = {a_rvalid, b_rvalid};
        ec[1:0] = {m_a_rv, m_b_rv};
        ord  = {a_rdata, b_rdata};
        erd  = {m_a_rd, m_b_rd};
        care = {{DW{m_a_rdk}}, {DW{m_b_rdk}}};
    endtask

    task automatic test_reset();
        drive_a(1, 0, 1, 0, 0); drive_b(1, 0, 2, 0, 0);
        rst_n = 0;
        #2;
        checks++;
        if ({a_ack, b_ack, a_rvalid, b_rvalid, a_rdata, b_rdata} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got ack=%b%b rv=%b%b rd=%h/%h want all 0",
                     a_ack, b_ack, a_rvalid, b_rvalid, a_rdata, b_rdata);
        end
        checks++;
        if (init_busy !== (EXP_BUSY > 0)) begin
            errors++; $display("FAIL reset_busy got %b want %b", init_busy, EXP_BUSY > 0);
        end
        drive_a(0, 0, 0, 0, 0); drive_b(0, 0, 0, 0, 0);
        @(posedge clk); #1;
        rst_n = 1;
        model_reset();
    endtask

    task automatic test_init();
        logic [4:0] oc, ec; logic [2*DW-1:0] ord, erd, care;
        int ack_at = -1, busy_n = 0;
`ifdef MEM_ARB_INIT_CLEAR_EN
        drive_a(1, 0, 5, 0, 0);
`else
        drive_a(1, 1, 5, 8'h5A, 2'b11);
`endif
        for (int i = 0; i < 40 && ack_at < 0; i++) begin
            cycle(oc, ec, ord, erd, care);
            checks++;
            if (oc !== ec) begin errors++; $display("FAIL init_ctl cyc%0d got %b want %b", i, oc, ec); end
            if (oc[2]) busy_n++;
            if (oc[4]) ack_at = i;
        end
        drive_a(0, 0, 0, 0, 0);
        checks++;
        if (ack_at !== EXP_BUSY) begin errors++; $display("FAIL init_ack_cycle got %0d want %0d", ack_at, EXP_BUSY); end
        checks++;
        if (busy_n !== EXP_BUSY) begin errors++; $display("FAIL init_busy_len got %0d want %0d", busy_n, EXP_BUSY); end
`ifdef MEM_ARB_INIT_CLEAR_EN
        checks++;
        if (oc[1] !== 1'b1 || ord[2*DW-1:DW] !== 8'h00) begin
            errors++; $display("FAIL init_read got rv=%b rd=%h want rv=1 rd=00", oc[1], ord[2*DW-1:DW]);
        end
`else
        checks++;
        if (oc[1] !== 1'b0) begin errors++; $display("FAIL init_write_rvalid got %b want 0", oc[1]); end
`endif
    endtask

    task automatic test_fill();
        logic [4:0] oc, ec; logic [2*DW-1:0] ord, erd, care;
        for (int i = 0; i < DEPTH; i++) begin
            drive_a(1, 1, i, DW'($urandom), 2'b11);
            cycle(oc, ec, ord, erd, care);
            checks++;
            if (oc !== ec) begin errors++; $display("FAIL fill_ctl addr%0d got %b want %b", i, oc, ec); end
        end
        drive_a(0, 0, 0, 0, 0);
    endtask

    task automatic test_rw_mask();
        logic [4:0] oc, ec; logic [2*DW-1:0] ord, erd, care;
        drive_a(1, 1, 3, 8'hA5, 2'b11);
        cycle(oc, ec, ord, erd, care);
        drive_a(0, 0, 0, 0, 0); drive_b(1, 0, 3, 0, 0);
        cycle(oc, ec, ord, erd, care);
        checks++;
        if (oc[3] !== 1'b1 || oc[0] !== 1'b1 || ord[DW-1:0] !== 8'hA5) begin
            errors++; $display("FAIL rw_b_read got ack=%b rv=%b rd=%h want 1 1 a5", oc[3], oc[0], ord[DW-1:0]);
        end
        drive_b(0, 0, 0, 0, 0); drive_a(1, 1, 3, 8'h3C, 2'b01);
        cycle(oc, ec, ord, erd, care);
        checks++;
        if (oc[1:0] !== 2'b00) begin errors++; $display("FAIL rw_write_rvalid got %b want 00", oc[1:0]); end
        drive_a(1, 1, 3, 8'hFF, 2'b00);
        cycle(oc, ec, ord, erd, care);
        checks++;
        if (oc[4] !== 1'b1) begin errors++; $display("FAIL mask00_ack got %b want 1", oc[4]); end
        drive_a(1, 0, 3, 0, 0);
        cycle(oc, ec, ord, erd, care);
        drive_a(0, 0, 0, 0, 0);
        checks++;
        if (oc[1] !== 1'b1 || ord[2*DW-1:DW] !== 8'hAC) begin
            errors++; $display("FAIL mask_read got rv=%b rd=%h want 1 ac", oc[1], ord[2*DW-1:DW]);
        end
        cycle(oc, ec, ord, erd, care);
        checks++;
        if (oc[1] !== 1'b0 || ord[2*DW-1:DW] !== 8'hAC) begin
            errors++; $display("FAIL rdata_hold got rv=%b rd=%h want 0 ac", oc[1], ord[2*DW-1:DW]);
        end
    endtask

    // A wins, idle cycles follow, then a tie: B must still be owed the grant.
    task automatic test_idle_prio();
        logic [4:0] oc, ec; logic [2*DW-1:0] ord, erd, care;
        drive_a(1, 0, 1, 0, 0);
        cycle(oc, ec, ord, erd, care);
        drive_a(0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cycle(oc, ec, ord, erd, care);
        drive_a(1, 0, 2, 0, 0); drive_b(1, 0, 4, 0, 0);
        cycle(oc, ec, ord, erd, care);
        drive_a(0, 0, 0, 0, 0); drive_b(0, 0, 0, 0, 0);
        checks++;
        if (oc[4:3] !== 2'b01) begin errors++; $display("FAIL idle_prio got ack=%b want 01", oc[4:3]); end
        checks++;
        if ((ord & care) !== (erd & care)) begin errors++; $display("FAIL idle_prio_rd got %h want %h", ord, erd); end
    endtask

    task automatic test_alternate();
        logic [4:0] oc, ec; logic [2*DW-1:0] ord, erd, care;
        int n = 0; bit prev_a = 0;
        test_reset();
        drive_a(1, 0, 6, 0, 0); drive_b(1, 0, 7, 0, 0);
        for (int i = 0; i < EXP_BUSY + 10; i++) begin
            cycle(oc, ec, ord, erd, care);
            checks++;
            if (oc !== ec) begin errors++; $display("FAIL alt_ctl cyc%0d got %b want %b", i, oc, ec); end
            if (oc[4] || oc[3]) begin
                checks++;
                if ((n == 0 && !oc[4]) || (n > 0 && oc[4] == prev_a)) begin
                    errors++; $display("FAIL alt_order grant%0d got A=%b prevA=%b", n, oc[4], prev_a);
                end
                prev_a = oc[4]; n++;
            end
        end
        drive_a(0, 0, 0, 0, 0); drive_b(0, 0, 0, 0, 0);
        checks++;
        if (n !== 10) begin errors++; $display("FAIL alt_count got %0d want 10", n); end
    endtask

    task automatic test_random();
        logic [4:0] oc, ec; logic [2*DW-1:0] ord, erd, care;
        for (int i = 0; i < 400; i++) begin
            drive_a($urandom_range(0, 2) != 0, $urandom_range(0, 1), $urandom_range(0, DEPTH - 1),
                    DW'($urandom), 2'($urandom));
            drive_b($urandom_range(0, 2) != 0, $urandom_range(0, 1), $urandom_range(0, DEPTH - 1),
                    DW'($urandom), 2'($urandom));
            cycle(oc, ec, ord, erd, care);
            checks++;
            if (oc !== ec) begin errors++; $display("FAIL rand_ctl cyc%0d got %b want %b", i, oc, ec); end
            checks++;
            if ((ord & care) !== (erd & care)) begin
                errors++; $display("FAIL rand_rd cyc%0d got %h want %h", i, ord & care, erd & care);
            end
        end
        drive_a(0, 0, 0, 0, 0); drive_b(0, 0, 0, 0, 0);
    endtask

    task automatic test_reset_during_read();
        logic [4:0] oc, ec; logic [2*DW-1:0] ord, erd, care;
        int busy_n = 0;
        drive_a(1, 0, 3, 0, 0);
        #3;
        checks++;
        if (a_ack !== 1'b1) begin errors++; $display("FAIL rst_rd_ack got %b want 1", a_ack); end
        #1 rst_n = 0;
        #1;
        checks++;
        if (a_ack !== 1'b0) begin errors++; $display("FAIL rst_rd_ack_drop got %b want 0", a_ack); end
        drive_a(0, 0, 0, 0, 0);
        @(posedge clk); #1;
        checks++;
        if (a_rvalid !== 1'b0 || a_rdata !== '0) begin
            errors++; $display("FAIL rst_rd_rvalid got rv=%b rd=%h want 0 00", a_rvalid, a_rdata);
        end
        @(posedge clk); #1;
        rst_n = 1;
        model_reset();
        for (int i = 0; i < EXP_BUSY + 3; i++) begin
            cycle(oc, ec, ord, erd, care);
            checks++;
            if (oc !== ec) begin errors++; $display("FAIL rst_rd_ctl cyc%0d got %b want %b", i, oc, ec); end
            if (oc[2]) busy_n++;
        end
        checks++;
        if (busy_n !== EXP_BUSY) begin errors++; $display("FAIL rst_rd_busy_len got %0d want %0d", busy_n, EXP_BUSY); end
    endtask

    initial begin
        test_reset();
        test_init();
        test_fill();
        test_rw_mask();
        test_idle_prio();
        test_alternate();
        test_random();
        test_reset_during_read();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
